idli_sgrf_m: RTL and testbench
==============================

IDLI_SGRF_M -- requirements
Module: idli_sgrf_m

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning register count; power of two, at least 4; register 0 is hard zero.
REQ-002 SHALL have parameter WORD_W, default 16, meaning register width in bits.
REQ-003 SHALL have parameter BEAT_W, default 4, meaning bits transferred per beat; WORD_W/BEAT_W (BEATS) is an integer of at least 2.
REQ-004 SHALL have parameter NUM_RD, default 2, meaning read port count, at least 1.
REQ-005 SHALL have parameter PC_REG, default NUM_REGS-1, meaning index of the program-counter register; nonzero.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 Ports: i_sgrf_gck  in  1  clock, rising edge.
REQ-008 Ports: i_sgrf_rst  in  1  asynchronous active-high reset.
REQ-009 Ports: i_sgrf_en  in  1  beat advance enable; low freezes all state.
REQ-010 Ports: i_sgrf_rd  in  NUM_RD*RW  read indices, flattened, port k at [k*RW +: RW], where RW = clog2(NUM_REGS).
REQ-011 Ports: o_sgrf_rd_data  out  NUM_RD*BEAT_W  current beat of each read register, flattened the same way.
REQ-012 Ports: i_sgrf_wr_vld / i_sgrf_wr / i_sgrf_wr_data  in  1 / RW / BEAT_W  write request, destination, beat data.
REQ-013 Ports: i_sgrf_pc_ld / i_sgrf_pc_inc / i_sgrf_pc_data  in  1 / 1 / BEAT_W  PC load, PC increment, PC load beat data.
REQ-014 Ports: o_sgrf_pc_data  out  BEAT_W  current beat of PC (pre-update value).
REQ-015 Ports: o_sgrf_beat  out  clog2(BEATS)  current beat number; o_sgrf_last  out  1  high when beat == BEATS-1.

Function
REQ-016 Each register SHALL be stored as a rotating shift register: every enabled cycle, {new_beat, reg[WORD_W-1:BEAT_W]}; beat 0 carries bits [BEAT_W-1:0].
REQ-017 The beat counter SHALL increment on each enabled cycle and wrap from BEATS-1 to 0.
REQ-018 Read data SHALL be combinational: the low beat of the indexed register; index 0 reads all zeros; out-of-range indices are not possible by width.
REQ-019 Operation mode SHALL be captured only on an enabled beat-0 cycle, with one of IDLE, WRITE, LOAD, INC, and held through beat BEATS-1.
REQ-020 Capture priority SHALL be: wr_vld with wr != 0 -> WRITE (destination latched); else pc_ld -> LOAD; else pc_inc -> INC; else IDLE.
REQ-021 Requests presented on beats 1..BEATS-1 SHALL be ignored, including when the current mode is IDLE.
REQ-022 In WRITE mode, every beat (beat 0 included) SHALL rotate i_sgrf_wr_data into the latched destination; this also applies when the destination is PC_REG, overriding pc_ld and pc_inc.
REQ-023 In LOAD mode, every beat SHALL rotate i_sgrf_pc_data into PC_REG.
REQ-024 In INC mode, PC_REG SHALL receive the serial sum of its low beat plus carry, where the carry-in is 1 at beat 0 and the carry flop holds the beat carry-out; the final carry is discarded (wrap 0xFFFF -> 0x0000).
REQ-025 Registers not being written SHALL rotate their own low beat, so each one returns to its original alignment after BEATS enabled cycles.
REQ-026 A write with wr == 0 SHALL be discarded; register 0 has no storage.
REQ-027 When i_sgrf_en is low, registers, the beat counter, the mode, the latched destination and the carry SHALL hold, and outputs SHALL follow held state.
REQ-028 o_sgrf_pc_data SHALL equal the low beat of PC_REG before any update in that cycle.

Reset
REQ-029 Reset assertion SHALL asynchronously clear all registers to 0, the beat counter to 0, the mode to IDLE, the latched destination and the carry to 0.
REQ-030 While reset is asserted, all outputs SHALL read 0 and o_sgrf_last SHALL read 0.
REQ-031 Reset asserted mid-word SHALL abort the in-flight operation; the partially written register SHALL be left at 0, with no residual beats.
REQ-032 The first enabled cycle after reset deassertion SHALL be beat 0.

Verification
REQ-033 Write 0xBEEF to r3 over 4 beats (data F,E,E,B), then read r3 on port 1 for 4 beats -> F,E,E,B; r3 never visible on other ports.
REQ-034 PC=0x00FF, INC for one word -> PC reads 0x0100; PC=0xFFFF, INC -> 0x0000; carry cleared at the next beat 0.
REQ-035 Beat 0 with wr_vld (wr=PC_REG, data 0x1234) together with pc_inc -> PC=0x1234, with no increment applied.
REQ-036 Write r2 with i_sgrf_en toggled low on beats 1 and 2 -> counter and data are held; r2 is correct after 4 enabled cycles.
REQ-037 wr_vld asserted only at beat 2 -> no register changes; write to r0 -> r0 reads 0.
REQ-038 Reset asserted at beat 2 of a write to r5 -> all registers are 0, o_sgrf_beat is 0, and the next word starts cleanly.

Source files
------------

// File: rtl/idli_sgrf_m.sv
// Bit-serial register file. Each register is a rotating shift register that
// presents one BEAT_W-bit beat per enabled cycle, low beat first. A word-long
// operation (write, PC load, PC increment) is chosen on beat 0 and held for
// the rest of the word. Register 0 has no storage and always reads zero.
module idli_sgrf_m #(
  parameter int NUM_REGS = 8,
  parameter int WORD_W   = 16,
  parameter int BEAT_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int PC_REG   = NUM_REGS - 1
) (
  input  logic                                    i_sgrf_gck,
  input  logic                                    i_sgrf_rst,
  input  logic                                    i_sgrf_en,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]      i_sgrf_rd,
  output logic [NUM_RD*BEAT_W-1:0]                o_sgrf_rd_data,
  input  logic                                    i_sgrf_wr_vld,
  input  logic [$clog2(NUM_REGS)-1:0]             i_sgrf_wr,
  input  logic [BEAT_W-1:0]                       i_sgrf_wr_data,
  input  logic                                    i_sgrf_pc_ld,
  input  logic                                    i_sgrf_pc_inc,
  input  logic [BEAT_W-1:0]                       i_sgrf_pc_data,
  output logic [BEAT_W-1:0]                       o_sgrf_pc_data,
  output logic [$clog2(WORD_W/BEAT_W)-1:0]        o_sgrf_beat,
  output logic                                    o_sgrf_last
);

  localparam int RW    = $clog2(NUM_REGS);
  localparam int BEATS = WORD_W / BEAT_W;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_WRITE,
    MODE_LOAD,
    MODE_INC
  } mode_e;

  // Storage for registers 1..NUM_REGS-1 only; register 0 is a constant zero.
  logic [WORD_W-1:0] regs_q [1:NUM_REGS-1];
  logic [BW-1:0]     beat_q;
  mode_e             mode_q;
  logic [RW-1:0]     dest_q;
  logic              carry_q;

  logic [BEAT_W-1:0] lowBeat [NUM_REGS];
  logic [BEAT_W-1:0] newBeat [1:NUM_REGS-1];
  mode_e             capMode;
  logic [RW-1:0]     capDest;
  mode_e             effMode;
  logic [RW-1:0]     effDest;
  logic              beatZero;
  logic              carryIn;
  logic [BEAT_W:0]   incSum;

  // Current low beat of every register, with index 0 tied to zero so read
  // ports can be indexed directly by the full index width.
  always_comb begin
    lowBeat[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      lowBeat[i] = regs_q[i][BEAT_W-1:0];
    end
  end

  // Combinational read ports.
  always_comb begin
    o_sgrf_rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      o_sgrf_rd_data[k*BEAT_W +: BEAT_W] = lowBeat[i_sgrf_rd[k*RW +: RW]];
    end
  end

  assign o_sgrf_pc_data = lowBeat[PC_REG];
  assign o_sgrf_beat    = beat_q;
  assign o_sgrf_last    = (beat_q == LAST_BEAT);
  assign beatZero       = (beat_q == '0);

  // Mode selection presented on beat 0; a write to r0 falls through to the
  // PC requests as if no write were asked for.
  always_comb begin
    capMode = MODE_IDLE;
    capDest = '0;
    if (i_sgrf_wr_vld && (i_sgrf_wr != '0)) begin
      capMode = MODE_WRITE;
      capDest = i_sgrf_wr;
    end else if (i_sgrf_pc_ld) begin
      capMode = MODE_LOAD;
    end else if (i_sgrf_pc_inc) begin
      capMode = MODE_INC;
    end
  end

  // Beat 0 acts on the freshly selected mode; later beats use the held one.
  always_comb begin
    effMode = beatZero ? capMode : mode_q;
    effDest = beatZero ? capDest : dest_q;
    carryIn = beatZero ? 1'b1 : carry_q;
    incSum  = {1'b0, lowBeat[PC_REG]} + {{BEAT_W{1'b0}}, carryIn};
  end

  // Beat to shift into the top of each register; a write to the PC wins over
  // load/increment, everything else recirculates its own low beat.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      newBeat[i] = lowBeat[i];
      if ((effMode == MODE_WRITE) && (effDest == RW'(i))) begin
        newBeat[i] = i_sgrf_wr_data;
      end else if ((i == PC_REG) && (effMode == MODE_LOAD)) begin
        newBeat[i] = i_sgrf_pc_data;
      end else if ((i == PC_REG) && (effMode == MODE_INC)) begin
        newBeat[i] = incSum[BEAT_W-1:0];
      end
    end
  end

  // Rotate every register by one beat on each enabled cycle.
  always_ff @(posedge i_sgrf_gck or posedge i_sgrf_rst) begin
    if (i_sgrf_rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (i_sgrf_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= {newBeat[i], regs_q[i][WORD_W-1:BEAT_W]};
      end
    end
  end

  // Beat counter, held mode/destination and the serial increment carry.
  always_ff @(posedge i_sgrf_gck or posedge i_sgrf_rst) begin
    if (i_sgrf_rst) begin
      beat_q  <= '0;
      mode_q  <= MODE_IDLE;
      dest_q  <= '0;
      carry_q <= 1'b0;
    end else if (i_sgrf_en) begin
      beat_q  <= (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
      if (beatZero) begin
        mode_q <= capMode;
        dest_q <= capDest;
      end
      carry_q <= (effMode == MODE_INC) ? incSum[BEAT_W] : 1'b0;
    end
  end

endmodule

// File: tb/tb_idli_sgrf_m.sv
// Directed bench for idli_sgrf_m at default parameters (8 x 16-bit regs,
// 4-bit beats, two read ports, PC = r7).
module tb_idli_sgrf_m;

  logic        clk;
  logic        rst;
  logic        en;
  logic [5:0]  rd;
  logic [7:0]  rdData;
  logic        wrVld;
  logic [2:0]  wr;
  logic [3:0]  wrData;
  logic        pcLd;
  logic        pcInc;
  logic [3:0]  pcData;
  logic [3:0]  pcOut;
  logic [1:0]  beat;
  logic        last;

  int errors = 0;
  int checks = 0;

  logic [15:0] w0, w1, pcw;

  idli_sgrf_m dut (
    .i_sgrf_gck     (clk),
    .i_sgrf_rst     (rst),
    .i_sgrf_en      (en),
    .i_sgrf_rd      (rd),
    .o_sgrf_rd_data (rdData),
    .i_sgrf_wr_vld  (wrVld),
    .i_sgrf_wr      (wr),
    .i_sgrf_wr_data (wrData),
    .i_sgrf_pc_ld   (pcLd),
    .i_sgrf_pc_inc  (pcInc),
    .i_sgrf_pc_data (pcData),
    .o_sgrf_pc_data (pcOut),
    .o_sgrf_beat    (beat),
    .o_sgrf_last    (last)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every request input in one go.
  task automatic applyStimulus(input logic vld, input logic [2:0] dst,
                               input logic [3:0] wd, input logic ld,
                               input logic inc, input logic [3:0] pd,
                               input logic e);
    wrVld  = vld;
    wr     = dst;
    wrData = wd;
    pcLd   = ld;
    pcInc  = inc;
    pcData = pd;
    en     = e;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  // Serially write a full word, starting on beat 0.
  task automatic writeWord(input logic [2:0] dst, input logic [15:0] w);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, dst, w[b*4 +: 4], 1'b0, 1'b0, 4'h0, 1'b1);
      tick();
    end
    idle();
  endtask

  task automatic loadPc(input logic [15:0] w);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 1'b0, w[b*4 +: 4], 1'b1);
      tick();
    end
    idle();
  endtask

  task automatic incPc;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1);
      tick();
    end
    idle();
  endtask

  // Read one idle word on both ports and the PC, checking beat/last as it goes.
  task automatic readWord(input logic [2:0] i0, input logic [2:0] i1,
                          output logic [15:0] r0, output logic [15:0] r1,
                          output logic [15:0] rpc);
    idle();
    rd = {i1, i0};
    r0 = '0; r1 = '0; rpc = '0;
    for (int b = 0; b < 4; b++) begin
      #1;
      checkOutput("read_beat", {30'd0, beat}, b);
      checkOutput("read_last", {31'd0, last}, (b == 3) ? 32'd1 : 32'd0);
      r0[b*4 +: 4]  = rdData[3:0];
      r1[b*4 +: 4]  = rdData[7:4];
      rpc[b*4 +: 4] = pcOut;
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    rd  = 6'd0;
    applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    #1 rst = 1'b1;
    #1;
    rd = {3'd7, 3'd3};
    #1;
    checkOutput("rst_beat", {30'd0, beat}, 0);
    checkOutput("rst_last", {31'd0, last}, 0);
    checkOutput("rst_rd", {24'd0, rdData}, 0);
    checkOutput("rst_pc", {28'd0, pcOut}, 0);

    // Requests and clocks while reset is held must not disturb anything.
    applyStimulus(1'b1, 3'd3, 4'hF, 1'b1, 1'b1, 4'hF, 1'b1);
    tick(); tick(); tick();
    checkOutput("rst_hold_beat", {30'd0, beat}, 0);
    checkOutput("rst_hold_rd", {24'd0, rdData}, 0);
    checkOutput("rst_hold_pc", {28'd0, pcOut}, 0);
    idle();
    rst = 1'b0;
    #1;
    checkOutput("first_beat", {30'd0, beat}, 0);

    // Write 0xBEEF to r3, read it back on port 1; port 0 looks at empty r2.
    writeWord(3'd3, 16'hBEEF);
    readWord(3'd2, 3'd3, w0, w1, pcw);
    checkOutput("r3_port1", {16'd0, w1}, 32'hBEEF);
    checkOutput("r2_port0", {16'd0, w0}, 32'h0000);
    readWord(3'd3, 3'd1, w0, w1, pcw);
    checkOutput("r3_port0", {16'd0, w0}, 32'hBEEF);
    checkOutput("r1_port1", {16'd0, w1}, 32'h0000);

    // Serial increment with carry across beats, and full wrap.
    loadPc(16'h00FF);
    readWord(3'd7, 3'd0, w0, w1, pcw);
    checkOutput("pc_load", {16'd0, pcw}, 32'h00FF);
    checkOutput("pc_via_port", {16'd0, w0}, 32'h00FF);
    incPc();
    readWord(3'd0, 3'd0, w0, w1, pcw);
    checkOutput("pc_inc_carry", {16'd0, pcw}, 32'h0100);
    loadPc(16'hFFFF);
    incPc();
    readWord(3'd0, 3'd0, w0, w1, pcw);
    checkOutput("pc_inc_wrap", {16'd0, pcw}, 32'h0000);
    incPc();
    readWord(3'd0, 3'd0, w0, w1, pcw);
    checkOutput("pc_inc_after_wrap", {16'd0, pcw}, 32'h0001);

    // Write to PC together with load and increment: the write wins.
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, 3'd7, 4'(16'h1234 >> (b*4)), 1'b1, 1'b1, 4'hF, 1'b1);
      tick();
    end
    readWord(3'd7, 3'd3, w0, w1, pcw);
    checkOutput("pc_write_wins", {16'd0, pcw}, 32'h1234);
    checkOutput("r3_untouched", {16'd0, w1}, 32'hBEEF);

    // Write r2 = 0xA5C3 with enable dropped for two cycles after beat 0.
    applyStimulus(1'b1, 3'd2, 4'h3, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd2, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    checkOutput("en_low_beat1", {30'd0, beat}, 1);
    tick();
    checkOutput("en_low_beat2", {30'd0, beat}, 1);
    applyStimulus(1'b1, 3'd2, 4'hC, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd2, 4'h5, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd2, 4'hA, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    readWord(3'd2, 3'd7, w0, w1, pcw);
    checkOutput("r2_en_gap", {16'd0, w0}, 32'hA5C3);
    checkOutput("pc_after_r2", {16'd0, w1}, 32'h1234);

    // Requests arriving on beats 2 and 3 of an idle word are ignored.
    idle(); tick(); tick();
    applyStimulus(1'b1, 3'd4, 4'hF, 1'b1, 1'b1, 4'hF, 1'b1);
    tick(); tick();
    readWord(3'd4, 3'd7, w0, w1, pcw);
    checkOutput("late_wr_r4", {16'd0, w0}, 32'h0000);
    checkOutput("late_wr_pc", {16'd0, w1}, 32'h1234);

    // A write to r0 is discarded and r0 keeps reading zero.
    writeWord(3'd0, 16'h5555);
    readWord(3'd0, 3'd3, w0, w1, pcw);
    checkOutput("r0_zero", {16'd0, w0}, 32'h0000);
    checkOutput("r3_after_r0", {16'd0, w1}, 32'hBEEF);
    checkOutput("pc_after_r0", {16'd0, pcw}, 32'h1234);

    // Reset arriving at beat 2 of a write to r5 clears everything.
    applyStimulus(1'b1, 3'd5, 4'h9, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd5, 4'h8, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    checkOutput("pre_rst_beat", {30'd0, beat}, 2);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_beat", {30'd0, beat}, 0);
    tick();
    idle();
    rst = 1'b0;
    readWord(3'd5, 3'd3, w0, w1, pcw);
    checkOutput("r5_cleared", {16'd0, w0}, 32'h0000);
    checkOutput("r3_cleared", {16'd0, w1}, 32'h0000);
    checkOutput("pc_cleared", {16'd0, pcw}, 32'h0000);
    readWord(3'd2, 3'd0, w0, w1, pcw);
    checkOutput("r2_cleared", {16'd0, w0}, 32'h0000);
    writeWord(3'd5, 16'h1357);
    readWord(3'd5, 3'd6, w0, w1, pcw);
    checkOutput("r5_after_rst", {16'd0, w0}, 32'h1357);
    checkOutput("r6_after_rst", {16'd0, w1}, 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
